// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of an N_IN-input function, captures y into a table, checks it against a latched expectation.
// Latency: start accept -> done_o pulse is 2**N_IN*(SETTLE+1)+1 cycles; each vector is held SETTLE cycles plus one sample cycle.
// Backpressure: none; start is only taken in IDLE, abort cancels a running sweep, all outputs are registered.
module truth_table_sweeper #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [(1<<N_IN)-1:0]  exp_i,
  input  logic                  y_i,
  output logic [N_IN-1:0]       vec_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [(1<<N_IN)-1:0]  table_o,
  output logic [N_IN:0]         ones_o,
  output logic                  pass_o,
  output logic                  fail_valid_o,
  output logic [N_IN-1:0]       fail_idx_o,
  output logic                  aborted_o
);

  localparam int TW = 1 << N_IN;
  // Settle counter runs 0..SETTLE-1; keep at least one bit so SETTLE=1 still elaborates.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   exp_q;

  logic accept;
  logic sample_ok;
  logic abort_hit;
  logic last_vec;
  logic mismatch;
  logic first_fail;

  // Decode the events that every register group reacts to.
  always_comb begin
    accept     = (state == ST_IDLE) && start && !abort;
    abort_hit  = abort && ((state == ST_SETTLE) || (state == ST_SAMPLE));
    sample_ok  = (state == ST_SAMPLE) && !abort;
    last_vec   = (idx == IDX_LAST);
    mismatch   = (y_i != exp_q[idx]);
    first_fail = mismatch && !fail_valid_o;
  end

  // Sequencer: state, vector index, settle counter and the registered vec/busy/done outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      cnt    <= '0;
      vec_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state  <= ST_SETTLE;
            idx    <= '0;
            cnt    <= '0;
            vec_o  <= '0;
            busy_o <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state  <= ST_IDLE;
            vec_o  <= '0;
            busy_o <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state  <= ST_IDLE;
            vec_o  <= '0;
            busy_o <= 1'b0;
          end else if (last_vec) begin
            // Terminal index: no wrap, the sweep ends here.
            state  <= ST_DONE;
            vec_o  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            state <= ST_SETTLE;
            idx   <= idx + 1'b1;
            vec_o <= idx + 1'b1;
            cnt   <= '0;
          end
        end
        default: begin
          // ST_DONE lasts exactly one cycle.
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture: write y into the table and count ones on each non-aborted sample edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      table_o <= '0;
      ones_o  <= '0;
    end else if (accept) begin
      table_o <= '0;
      ones_o  <= '0;
    end else if (sample_ok) begin
      table_o[idx] <= y_i;
      ones_o       <= ones_o + (N_IN+1)'(y_i);
    end
  end

  // Verdict: latch the expected table, track the first mismatch, pass and abort status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q        <= '0;
      pass_o       <= 1'b0;
      fail_valid_o <= 1'b0;
      fail_idx_o   <= '0;
      aborted_o    <= 1'b0;
    end else if (accept) begin
      exp_q        <= exp_i;
      pass_o       <= 1'b0;
      fail_valid_o <= 1'b0;
      fail_idx_o   <= '0;
      aborted_o    <= 1'b0;
    end else begin
      if (abort_hit) begin
        aborted_o <= 1'b1;
      end
      // Only the first mismatch is recorded; later ones leave the index alone.
      if (sample_ok && first_fail) begin
        fail_valid_o <= 1'b1;
        fail_idx_o   <= idx;
      end
      // Include the final sample's own mismatch, since fail_valid_o updates on the same edge.
      if (sample_ok && last_vec) begin
        pass_o <= !(fail_valid_o || mismatch);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps against parity/AND functions with a done-driven scoreboard.
// Stimulus pushes expected sweep results; a negedge monitor pops and compares on each done_o pulse.
// Direct checks cover reset, vector stepping, abort, start-while-busy and reset mid-sweep.
module tb_truth_table_sweeper;

  localparam int N_IN   = 5;
  localparam int SETTLE = 2;
  localparam int TW     = 1 << N_IN;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [TW-1:0]   exp_i = '0;
  logic            y_i;
  logic [N_IN-1:0] vec_o;
  logic            busy_o;
  logic            done_o;
  logic [TW-1:0]   table_o;
  logic [N_IN:0]   ones_o;
  logic            pass_o;
  logic            fail_valid_o;
  logic [N_IN-1:0] fail_idx_o;
  logic            aborted_o;

  bit use_and = 1'b0;
  assign y_i = use_and ? (&vec_o) : (^vec_o);

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .exp_i        (exp_i),
    .y_i          (y_i),
    .vec_o        (vec_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .table_o      (table_o),
    .ones_o       (ones_o),
    .pass_o       (pass_o),
    .fail_valid_o (fail_valid_o),
    .fail_idx_o   (fail_idx_o),
    .aborted_o    (aborted_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] tbl;
    logic [5:0]  ones;
    logic        pass;
    logic        fv;
    logic [4:0]  fidx;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int t0       = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".vec"},        vec_o, 0);
    chk({tag, ".busy"},       busy_o, 0);
    chk({tag, ".done"},       done_o, 0);
    chk({tag, ".table"},      table_o, 0);
    chk({tag, ".ones"},       ones_o, 0);
    chk({tag, ".pass"},       pass_o, 0);
    chk({tag, ".fail_valid"}, fail_valid_o, 0);
    chk({tag, ".fail_idx"},   fail_idx_o, 0);
    chk({tag, ".aborted"},    aborted_o, 0);
  endtask

  // Walk negedges until cycle t0+rel (cycle 0 = accept cycle).
  task automatic wait_to(input int rel);
    while (cyc - t0 < rel) @(negedge clk);
  endtask

  // Called at a negedge: start is seen by the next rising edge, so this cycle is cycle 0.
  task automatic do_start(input logic [31:0] e);
    start = 1'b1;
    exp_i = e;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] tbl, input int ones, input bit pass,
                          input bit fv, input int fidx);
    exp_t ex;
    ex.tbl      = tbl;
    ex.ones     = 6'(ones);
    ex.pass     = pass;
    ex.fv       = fv;
    ex.fidx     = 5'(fidx);
    ex.done_cyc = cyc + (TW * (SETTLE + 1)) + 1;
    sb.push_back(ex);
  endtask

  // Full parity sweep; optionally re-pulse start at cycle 40 with a bogus expected table.
  task automatic parity_sweep(input bit repulse);
    use_and = 1'b0;
    push_exp(32'h96696996, 16, 1'b1, 1'b0, 0);
    do_start(32'h96696996);
    for (int c = 1; c <= 96; c++) begin
      wait_to(c);
      chk("sweep.busy", busy_o, 1);
      chk("sweep.vec", vec_o, (c - 1) / 3);
      if (repulse && c == 40) begin
        start = 1'b1;
        exp_i = 32'h0;
      end else if (repulse && c == 41) begin
        start = 1'b0;
        exp_i = 32'h96696996;
      end
    end
    wait_to(97);
    chk("sweep.done97", done_o, 1);
    chk("sweep.busy97", busy_o, 0);
    chk("sweep.vec97", vec_o, 0);
    wait_to(98);
    chk("sweep.done98", done_o, 0);
    chk("sweep.pass_held", pass_o, 1);
    chk("sweep.table_held", table_o, 32'h96696996);
  endtask

  // Scoreboard monitor: every done_o pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: done_o=1, expected no completion", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("mon.done_cycle", cyc, mon_e.done_cyc);
        chk("mon.table", table_o, mon_e.tbl);
        chk("mon.ones", ones_o, mon_e.ones);
        chk("mon.pass", pass_o, mon_e.pass);
        chk("mon.fail_valid", fail_valid_o, mon_e.fv);
        chk("mon.fail_idx", fail_idx_o, mon_e.fidx);
        chk("mon.aborted", aborted_o, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, n_checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for three cycles, then released into IDLE.
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // Parity with exact expected table.
    parity_sweep(1'b0);

    // Abort in the second settle cycle of vector 6.
    use_and = 1'b0;
    do_start(32'h96696996);
    wait_to(20);
    abort = 1'b1;
    wait_to(21);
    abort = 1'b0;
    chk("abort.busy", busy_o, 0);
    chk("abort.vec", vec_o, 0);
    chk("abort.aborted", aborted_o, 1);
    chk("abort.done", done_o, 0);
    chk("abort.table", table_o, 32'h00000016);
    chk("abort.ones", ones_o, 3);
    chk("abort.fail_valid", fail_valid_o, 0);
    wait_to(110);
    chk("abort.aborted_sticky", aborted_o, 1);
    chk("abort.table_kept", table_o, 32'h00000016);

    // AND function with one deliberate mismatch at index 13.
    use_and = 1'b1;
    push_exp(32'h80000000, 1, 1'b0, 1'b1, 13);
    do_start(32'h80002000);
    chk("and.aborted_cleared", aborted_o, 0);
    chk("and.table_cleared", table_o, 0);
    wait_to(42);
    chk("and.fail_valid42", fail_valid_o, 0);
    wait_to(43);
    chk("and.fail_valid43", fail_valid_o, 1);
    chk("and.fail_idx43", fail_idx_o, 13);
    wait_to(98);
    chk("and.pass_held", pass_o, 0);
    chk("and.done98", done_o, 0);

    // start+abort together in IDLE: abort wins, nothing changes.
    start = 1'b1;
    abort = 1'b1;
    exp_i = 32'h0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa.busy", busy_o, 0);
    chk("sa.vec", vec_o, 0);
    chk("sa.table", table_o, 32'h80000000);
    chk("sa.fail_valid", fail_valid_o, 1);
    chk("sa.fail_idx", fail_idx_o, 13);
    chk("sa.ones", ones_o, 1);
    repeat (3) @(negedge clk);
    chk("sa.busy_later", busy_o, 0);

    // Start while busy is ignored; expected table is not re-latched.
    parity_sweep(1'b1);

    // Reset mid-sweep discards everything and produces no done.
    use_and = 1'b0;
    do_start(32'h96696996);
    wait_to(50);
    chk("rst.busy_before", busy_o, 1);
    rst_n = 1'b0;
    wait_to(51);
    check_zero("rst_mid");
    rst_n = 1'b1;
    wait_to(110);
    chk("rst.busy_after", busy_o, 0);
    chk("rst.table_after", table_o, 0);

    // A clean sweep after the mid-sweep reset.
    parity_sweep(1'b0);

    repeat (3) @(negedge clk);
    chk("sb.drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
